spu_sprite_writer: RTL and testbench
====================================

// Module: spu_sprite_writer
// PURPOSE
//  Write side of the SPU -> frame-buffer interface: produces the spupointer/spudata
//  stream that the VGA display block consumes. Accepts one sprite-draw command at a
//  time, fetches SPR x SPR 9-bit RGB333 pixels from sprite ROM and writes each visible,
//  non-transparent pixel to the frame buffer. Clips at the screen edges. Sits between
//  the command sequencer and the frame buffer write port.
// PARAMETERS
//  FB_W      256     frame width in pixels; power of two, <= 256
//  FB_H      192     frame height in lines; FB_W*FB_H <= 65536
//  SPR       16      sprite edge in pixels; power of two (SPR_LG = log2(SPR))
//  TRANSP    9'h000  colour key; pixels equal to it are skipped
// PORTS
//  clk         in   1       master clock
//  rst_n       in   1       asynchronous, active-low reset
//  cmd_valid   in   1       draw command present
//  cmd_ready   out  1       block can accept a command (high only in IDLE)
//  cmd_x       in   9       sprite left edge, screen pixels (unsigned)
//  cmd_y       in   9       sprite top edge, screen lines (unsigned)
//  cmd_id      in   6       sprite index in ROM
//  rom_addr    out  6+2*SPR_LG  {id,row,col}; rom_data valid the following cycle
//  rom_data    in   9       sprite pixel, RGB333
//  spupointer  out  16      frame-buffer address = (y+row)*FB_W + (x+col)
//  spudata     out  9       pixel written
//  spuwe       out  1       write strobe; beat completes when spuwe & spu_ready
//  spu_ready   in   1       frame buffer accepts the write this cycle
//  busy        out  1       command in progress
//  done        out  1       one-cycle pulse after the last pixel of a command
// BEHAVIOUR
//  Reset: all state -> IDLE; cmd_ready=1; spuwe=0; busy=0; done=0;
//   spupointer=0; spudata=0; rom_addr=0; row/col counters=0.
//  FSM: IDLE -> FETCH -> WAIT -> (WRITE | NEXT) -> FETCH ... -> DONE -> IDLE.
//  IDLE: cmd_ready=1. On cmd_valid, register x,y,id; clear row and col; go to FETCH.
//  FETCH: drive rom_addr={id,row,col}; go to WAIT.
//  WAIT: rom_data valid; compute px=x+col, py=y+row at 10 bits (no wrap).
//   Visible iff px<FB_W and py<FB_H and rom_data!=TRANSP.
//   Visible: load spupointer={py,px} truncated to 16 bits, spudata=rom_data;
//   go to WRITE. Not visible: go to NEXT.
//  WRITE: spuwe=1; hold spupointer and spudata stable until spu_ready; then NEXT.
//  NEXT: col+1; when col wraps from SPR-1, col=0 and row+1.
//   After pixel (SPR-1,SPR-1), go to DONE; otherwise go to FETCH.
//  DONE: done=1 for exactly one cycle; go to IDLE.
//  busy=1 in every state except IDLE. cmd_valid is ignored while busy; no queueing.
//  Latency: cmd accept -> first spuwe = 3 cycles.
//   Minimum rate is 1 pixel / 4 cycles with spu_ready held high.
//  A fully off-screen sprite runs all SPR*SPR fetches with no writes, then pulses done.
//  Asserting rst_n low mid-command aborts immediately: spuwe drops and nothing resumes.
// STRUCTURE
//  Shared package spu_pkg: FB_W/FB_H/SPR defaults, rgb333_t (9-bit), TRANSP,
//   FSM state enum.
//  One sub-module: spu_clip_addr, combinational: {x,y,row,col} -> {visible_xy, addr}.
//  Everything else (FSM, counters, output regs) stays in this file.
// TESTING
//  1. Reset, cmd x=0,y=0,id=1, ROM all 9'h1FF, spu_ready=1
//     -> 256 writes, addrs 0..15 + k*256 (k=0..15), one done pulse.
//  2. cmd x=250,y=0 -> only col 0..5 written (px 250..255), 96 writes; no address > 0x0FFF.
//  3. cmd x=0,y=188 -> rows 0..3 only; last write addr 191*256+15=0xBF0F.
//  4. ROM checkerboard with TRANSP=0 -> exactly 128 writes, none with spudata=0.
//  5. spu_ready low 5 cycles during a beat
//     -> spuwe/spupointer/spudata held constant, no dropped or duplicated beat.
//  6. rst_n low while busy -> next cycle spuwe=0, busy=0, cmd_ready=1, no done pulse.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared types and defaults for the SPU sprite writer.
package spu_pkg;

   localparam int unsigned FbWDef = 256;
   localparam int unsigned FbHDef = 192;
   localparam int unsigned SprDef = 16;

   typedef logic [8:0] rgb333_t;

   // Colour key: sprite pixels equal to this are not written.
   localparam rgb333_t TranspDef = 9'h000;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StWrite,
      StNext,
      StDone
   } spu_state_e;

endpackage

// File: rtl/spu_clip_addr.sv
// Screen-space clip test and frame-buffer address for one sprite pixel.
module spu_clip_addr #(
   parameter int unsigned FB_W   = 256,
   parameter int unsigned FB_H   = 192,
   parameter int unsigned SPR_LG = 4
) (
   input  logic [8:0]        x_i,
   input  logic [8:0]        y_i,
   input  logic [SPR_LG-1:0] row_i,
   input  logic [SPR_LG-1:0] col_i,
   output logic              visible_xy_o,
   output logic [15:0]       addr_o
);

   localparam logic [9:0]  FbW10 = 10'(FB_W);
   localparam logic [9:0]  FbH10 = 10'(FB_H);
   localparam logic [15:0] FbW16 = 16'(FB_W);

   logic [9:0] px;
   logic [9:0] py;

   // 10-bit sums so positions past the right/bottom edge never wrap back on screen.
   always_comb begin
      px           = 10'(x_i) + 10'(col_i);
      py           = 10'(y_i) + 10'(row_i);
      visible_xy_o = (px < FbW10) && (py < FbH10);
      addr_o       = 16'(py) * FbW16 + 16'(px);
   end

endmodule

// File: rtl/spu_sprite_writer.sv
// Sprite blitter: walks an SPR x SPR sprite from ROM and writes visible pixels to the FB.
module spu_sprite_writer
   import spu_pkg::*;
#(
   parameter int unsigned FB_W   = FbWDef,
   parameter int unsigned FB_H   = FbHDef,
   parameter int unsigned SPR    = SprDef,
   parameter rgb333_t     TRANSP = TranspDef,
   localparam int unsigned SPR_LG = $clog2(SPR)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [8:0]            cmd_x,
   input  logic [8:0]            cmd_y,
   input  logic [5:0]            cmd_id,
   output logic [6+2*SPR_LG-1:0] rom_addr,
   input  logic [8:0]            rom_data,
   output logic [15:0]           spupointer,
   output logic [8:0]            spudata,
   output logic                  spuwe,
   input  logic                  spu_ready,
   output logic                  busy,
   output logic                  done
);

   spu_state_e        state_q, state_d;
   logic [8:0]        x_q, x_d;
   logic [8:0]        y_q, y_d;
   logic [5:0]        id_q, id_d;
   logic [SPR_LG-1:0] row_q, row_d;
   logic [SPR_LG-1:0] col_q, col_d;
   logic [15:0]       ptr_q, ptr_d;
   rgb333_t           data_q, data_d;

   logic              visible_xy;
   logic [15:0]       clip_addr;

   spu_clip_addr #(
      .FB_W   (FB_W),
      .FB_H   (FB_H),
      .SPR_LG (SPR_LG)
   ) u_clip (
      .x_i          (x_q),
      .y_i          (y_q),
      .row_i        (row_q),
      .col_i        (col_q),
      .visible_xy_o (visible_xy),
      .addr_o       (clip_addr)
   );

   // State, command and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         id_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         ptr_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         id_q    <= id_d;
         row_q   <= row_d;
         col_q   <= col_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
      end
   end

   // Next-state logic: fetch, wait for ROM, optionally write, advance pixel.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      id_d    = id_q;
      row_d   = row_q;
      col_d   = col_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               x_d     = cmd_x;
               y_d     = cmd_y;
               id_d    = cmd_id;
               row_d   = '0;
               col_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            if (visible_xy && (rom_data != TRANSP)) begin
               ptr_d   = clip_addr;
               data_d  = rom_data;
               state_d = StWrite;
            end else begin
               state_d = StNext;
            end
         end
         StWrite: begin
            if (spu_ready) state_d = StNext;
         end
         StNext: begin
            // SPR is a power of two, so the column counter wraps to 0 by itself.
            col_d = col_q + 1'b1;
            if (&col_q) begin
               if (&row_q) begin
                  state_d = StDone;
               end else begin
                  row_d   = row_q + 1'b1;
                  state_d = StFetch;
               end
            end else begin
               state_d = StFetch;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      cmd_ready  = (state_q == StIdle);
      busy       = (state_q != StIdle);
      done       = (state_q == StDone);
      spuwe      = (state_q == StWrite);
      rom_addr   = {id_q, row_q, col_q};
      spupointer = ptr_q;
      spudata    = data_q;
   end

endmodule

// File: tb/tb_spu_sprite_writer.sv
// Self-checking bench for spu_sprite_writer against a pixel-list reference model.
module tb_spu_sprite_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  cmd_x = '0;
   logic [8:0]  cmd_y = '0;
   logic [5:0]  cmd_id = '0;
   logic [13:0] rom_addr;
   logic [8:0]  rom_data;
   logic [15:0] spupointer;
   logic [8:0]  spudata;
   logic        spuwe;
   logic        spu_ready = 1'b1;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;

   spu_sprite_writer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_x      (cmd_x),
      .cmd_y      (cmd_y),
      .cmd_id     (cmd_id),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .spupointer (spupointer),
      .spudata    (spudata),
      .spuwe      (spuwe),
      .spu_ready  (spu_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Synchronous sprite ROM: 64 sprites x 256 pixels.
   logic [8:0] rom_mem [0:16383];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   // Monitor: completed beats and done pulses, sampled mid-cycle.
   logic [24:0] got_q[$];
   int          done_cnt = 0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (spuwe && spu_ready) got_q.push_back({spupointer, spudata});
         if (done) done_cnt++;
      end
   end

   logic [24:0] exp_q[$];

   // Reference: every sprite pixel that lands on the 256x192 screen and is not colour 0.
   function automatic void build_exp(int x, int y, int id);
      exp_q.delete();
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            int px = x + c;
            int py = y + r;
            logic [8:0] p = rom_mem[id * 256 + r * 16 + c];
            if (px < 256 && py < 192 && p != 9'h000)
               exp_q.push_back({16'(py * 256 + px), p});
         end
      end
   endfunction

   function automatic void fill_const(int id, logic [8:0] v);
      for (int i = 0; i < 256; i++) rom_mem[id * 256 + i] = v;
   endfunction

   function automatic void fill_random(int id);
      for (int i = 0; i < 256; i++)
         rom_mem[id * 256 + i] = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
   endfunction

   task automatic issue(input int x, input int y, input int id);
      @(posedge clk); #1;
      cmd_x     = 9'(x);
      cmd_y     = 9'(y);
      cmd_id    = 6'(id);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Runs until done is seen; lat = cycles from accept cycle to first spuwe.
   task automatic wait_done(input int d0, input bit bp, output int lat, output bit timed_out);
      int cyc = 1;
      lat = -1;
      while (done_cnt == d0 && cyc < 6000) begin
         if (spuwe && lat < 0) lat = cyc;
         spu_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      timed_out = (done_cnt == d0);
      spu_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic check_cmd(input string name, input int g0, input int d0, input bit timed_out);
      int n = got_q.size() - g0;
      int bad = -1;
      checks++;
      if (timed_out) begin
         failures++;
         $display("FAIL %s timeout: done not seen within budget", name);
      end
      checks++;
      if (done_cnt - d0 !== 1) begin
         failures++;
         $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
      end
      checks++;
      if (n !== exp_q.size()) begin
         failures++;
         $display("FAIL %s write_count: got %0d expected %0d", name, n, exp_q.size());
      end
      for (int i = 0; i < n && i < exp_q.size(); i++)
         if (bad < 0 && got_q[g0 + i] !== exp_q[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s write_%0d: got addr=%h data=%h expected addr=%h data=%h", name, bad,
                  got_q[g0 + bad][24:9], got_q[g0 + bad][8:0], exp_q[bad][24:9], exp_q[bad][8:0]);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, spuwe, busy, done} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_ctrl: got ready/we/busy/done=%b expected 1000",
                  {cmd_ready, spuwe, busy, done});
      end
      checks++;
      if (spupointer !== 16'h0 || spudata !== 9'h0 || rom_addr !== 14'h0) begin
         failures++;
         $display("FAIL reset_data: got ptr=%h data=%h rom_addr=%h expected 0 0 0",
                  spupointer, spudata, rom_addr);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_full();
      int g0 = got_q.size(), d0 = done_cnt, lat;
      bit to;
      fill_const(1, 9'h1FF);
      build_exp(0, 0, 1);
      issue(0, 0, 1);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("full", g0, d0, to);
      checks++;
      if (lat !== 3) begin
         failures++;
         $display("FAIL latency: got %0d cycles expected 3", lat);
      end
      checks++;
      if (got_q.size() - g0 !== 256) begin
         failures++;
         $display("FAIL full_256: got %0d writes expected 256", got_q.size() - g0);
      end
   endtask

   task automatic test_right_clip();
      int g0 = got_q.size(), d0 = done_cnt, lat, hi = 0;
      bit to;
      build_exp(250, 0, 1);
      issue(250, 0, 1);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("right_clip", g0, d0, to);
      for (int i = g0; i < got_q.size(); i++)
         if (int'(got_q[i][24:9]) > hi) hi = int'(got_q[i][24:9]);
      checks++;
      if (got_q.size() - g0 !== 96 || hi > 'h0FFF) begin
         failures++;
         $display("FAIL right_clip_bounds: got %0d writes max_addr=%h expected 96 and <=0fff",
                  got_q.size() - g0, hi);
      end
   endtask

   task automatic test_bottom_clip();
      int g0 = got_q.size(), d0 = done_cnt, lat;
      bit to;
      build_exp(0, 188, 1);
      issue(0, 188, 1);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("bottom_clip", g0, d0, to);
      checks++;
      if (got_q.size() <= g0 || got_q[got_q.size() - 1][24:9] !== 16'hBF0F) begin
         failures++;
         $display("FAIL bottom_last_addr: got %h expected bf0f",
                  (got_q.size() > g0) ? got_q[got_q.size() - 1][24:9] : 16'hxxxx);
      end
   endtask

   task automatic test_checker();
      int g0 = got_q.size(), d0 = done_cnt, lat, zeros = 0;
      bit to;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            rom_mem[2 * 256 + r * 16 + c] = ((r + c) % 2 == 1) ? 9'h000 : 9'h155;
      build_exp(0, 0, 2);
      issue(0, 0, 2);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("checker", g0, d0, to);
      for (int i = g0; i < got_q.size(); i++) if (got_q[i][8:0] == 9'h000) zeros++;
      checks++;
      if (got_q.size() - g0 !== 128 || zeros != 0) begin
         failures++;
         $display("FAIL checker_count: got %0d writes (%0d zero) expected 128 (0 zero)",
                  got_q.size() - g0, zeros);
      end
   endtask

   task automatic test_stall();
      int g0 = got_q.size(), d0 = done_cnt, lat, n = 0;
      bit to;
      logic [15:0] p0;
      logic [8:0]  v0;
      fill_random(3);
      rom_mem[3 * 256] = 9'h0A5;
      build_exp(40, 30, 3);
      issue(40, 30, 3);
      while (!spuwe && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      spu_ready = 1'b0;
      p0 = spupointer;
      v0 = spudata;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (spuwe !== 1'b1 || spupointer !== p0 || spudata !== v0) begin
            failures++;
            $display("FAIL stall_hold_%0d: got we=%b ptr=%h data=%h expected 1 %h %h",
                     i, spuwe, spupointer, spudata, p0, v0);
         end
      end
      wait_done(d0, 1'b0, lat, to);
      check_cmd("stall", g0, d0, to);
   endtask

   task automatic test_random();
      for (int k = 0; k < 6; k++) begin
         int g0 = got_q.size(), d0 = done_cnt, lat;
         int x = $urandom_range(0, 300);
         int y = $urandom_range(0, 220);
         int id = $urandom_range(0, 63);
         bit to;
         fill_random(id);
         build_exp(x, y, id);
         issue(x, y, id);
         wait_done(d0, 1'b1, lat, to);
         check_cmd($sformatf("random_%0d", k), g0, d0, to);
      end
   endtask

   task automatic test_offscreen();
      int g0 = got_q.size(), d0 = done_cnt, lat;
      bit to;
      build_exp(300, 0, 1);
      issue(300, 0, 1);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("offscreen", g0, d0, to);
   endtask

   task automatic test_abort();
      int g0, d0 = done_cnt, lat;
      bit to;
      fill_const(4, 9'h0F0);
      issue(10, 10, 4);
      repeat (37) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy_before: got %b expected 1", busy);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({spuwe, busy, cmd_ready, done} !== 4'b0010) begin
         failures++;
         $display("FAIL abort_state: got we/busy/ready/done=%b expected 0010",
                  {spuwe, busy, cmd_ready, done});
      end
      @(posedge clk); #1 rst_n = 1'b1;
      g0 = got_q.size();
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (done_cnt !== d0 || got_q.size() !== g0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_resume: got done=%0d writes=%0d busy=%b expected 0 0 0",
                  done_cnt - d0, got_q.size() - g0, busy);
      end
      // Block must still work normally afterwards.
      d0 = done_cnt;
      g0 = got_q.size();
      build_exp(10, 10, 4);
      issue(10, 10, 4);
      wait_done(d0, 1'b0, lat, to);
      check_cmd("after_abort", g0, d0, to);
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) rom_mem[i] = 9'h000;
      test_reset();
      test_full();
      test_right_clip();
      test_bottom_clip();
      test_checker();
      test_stall();
      test_random();
      test_offscreen();
      test_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
